instmem_loader: RTL and testbench

//  Write-side companion to the halfword-addressable instruction ROMs. Receives a byte

---
 rtl/instmem_loader_pkg.sv | 24 ++
 rtl/instmem_loader.sv | 184 ++++++++++++++++++
 tb/tb_instmem_loader.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instmem_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader: FSM states,
// command bytes, sizing defaults and the running-checksum helper.
package instmem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_LO  = 3'd1,
    ST_LEN_HI  = 3'd2,
    ST_DATA_LO = 3'd3,
    ST_DATA_HI = 3'd4,
    ST_CSUM    = 3'd5
  } state_e;

  localparam int         MEM_DEPTH_DEF   = 2048;
  localparam int         ADDR_W_DEF      = 11;
  localparam int         TIMEOUT_CYC_DEF = 100000;
  localparam logic [7:0] CMD_PROG_DEF    = 8'hA5;
  localparam logic [7:0] CMD_ISR_DEF     = 8'h5A;

  function automatic logic [7:0] csum_update(input logic [7:0] csum, input logic [7:0] b);
    return csum ^ b;
  endfunction

endpackage

// File: rtl/instmem_loader.sv
// Frames a byte stream into halfword writes for the main/ISR instruction memories,
// holding the core during a load and validating the trailing XOR checksum.
module instmem_loader
  import instmem_loader_pkg::*;
#(
  parameter int         MEM_DEPTH   = MEM_DEPTH_DEF,
  parameter int         ADDR_W      = ADDR_W_DEF,
  parameter logic [7:0] CMD_PROG    = CMD_PROG_DEF,
  parameter logic [7:0] CMD_ISR     = CMD_ISR_DEF,
  parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic              wr_sel_isr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int              TMR_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [15:0]     MAX_LEN  = 16'(MEM_DEPTH);

  state_e            state_r, state_s;
  logic              in_ready_r;
  logic              sel_r, sel_s;
  logic              hold_r, hold_s;
  logic [7:0]        len_lo_r, len_lo_s;
  logic [ADDR_W:0]   len_r, len_s;
  logic [ADDR_W-1:0] cnt_r, cnt_s;
  logic [7:0]        csum_r, csum_s;
  logic [7:0]        lo_r, lo_s;
  logic [TMR_W-1:0]  timer_r, timer_s;
  logic              wr_en_r, wr_en_s;
  logic [ADDR_W-1:0] wr_addr_r, wr_addr_s;
  logic [15:0]       wr_data_r, wr_data_s;
  logic              done_r, done_s;
  logic              err_r, err_s;
  logic              hs_s;
  logic [15:0]       len_full_s;
  logic [ADDR_W:0]   last_idx_s;

  assign hs_s       = in_valid & in_ready_r;
  assign len_full_s = {in_data, len_lo_r};
  assign last_idx_s = len_r - (ADDR_W + 1)'(1);

  // Next-state and next-output computation for the frame parser.
  always_comb begin
    state_s   = state_r;
    sel_s     = sel_r;
    hold_s    = hold_r;
    len_lo_s  = len_lo_r;
    len_s     = len_r;
    cnt_s     = cnt_r;
    csum_s    = csum_r;
    lo_s      = lo_r;
    timer_s   = {TMR_W{1'b0}};
    wr_en_s   = 1'b0;
    wr_addr_s = wr_addr_r;
    wr_data_s = wr_data_r;
    done_s    = 1'b0;
    err_s     = 1'b0;
    if (hs_s) begin
      case (state_r)
        ST_IDLE: begin
          // Non-command bytes are dropped so the parser resyncs on the next frame.
          if ((in_data == CMD_PROG) || (in_data == CMD_ISR)) begin
            sel_s   = (in_data == CMD_ISR);
            hold_s  = 1'b1;
            csum_s  = 8'h00;
            cnt_s   = {ADDR_W{1'b0}};
            state_s = ST_LEN_LO;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_LEN_LO: begin
          len_lo_s = in_data;
          state_s  = ST_LEN_HI;
        end
        ST_LEN_HI: begin
          if ((len_full_s == 16'h0000) || (len_full_s > MAX_LEN)) begin
            err_s   = 1'b1;
            state_s = ST_IDLE;
          end else begin
            len_s   = len_full_s[ADDR_W:0];
            state_s = ST_DATA_LO;
          end
        end
        ST_DATA_LO: begin
          lo_s    = in_data;
          csum_s  = csum_update(csum_r, in_data);
          state_s = ST_DATA_HI;
        end
        ST_DATA_HI: begin
          wr_en_s   = 1'b1;
          wr_addr_s = cnt_r;
          wr_data_s = {in_data, lo_r};
          csum_s    = csum_update(csum_r, in_data);
          if ({1'b0, cnt_r} == last_idx_s) begin
            state_s = ST_CSUM;
          end else begin
            cnt_s   = cnt_r + ADDR_W'(1);
            state_s = ST_DATA_LO;
          end
        end
        ST_CSUM: begin
          if (in_data == csum_r) begin
            done_s = 1'b1;
            hold_s = 1'b0;
          end else begin
            err_s  = 1'b1;
          end
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end else if (state_r != ST_IDLE) begin
      if (timer_r == TMR_LAST) begin
        err_s   = 1'b1;
        state_s = ST_IDLE;
      end else begin
        timer_s = timer_r + TMR_W'(1);
      end
    end else begin
      timer_s = {TMR_W{1'b0}};
    end
  end

  // State, datapath and registered-output update.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r    <= ST_IDLE;
      in_ready_r <= 1'b1;
      sel_r      <= 1'b0;
      hold_r     <= 1'b0;
      len_lo_r   <= 8'h00;
      len_r      <= {(ADDR_W + 1){1'b0}};
      cnt_r      <= {ADDR_W{1'b0}};
      csum_r     <= 8'h00;
      lo_r       <= 8'h00;
      timer_r    <= {TMR_W{1'b0}};
      wr_en_r    <= 1'b0;
      wr_addr_r  <= {ADDR_W{1'b0}};
      wr_data_r  <= 16'h0000;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      in_ready_r <= 1'b1;
      sel_r      <= sel_s;
      hold_r     <= hold_s;
      len_lo_r   <= len_lo_s;
      len_r      <= len_s;
      cnt_r      <= cnt_s;
      csum_r     <= csum_s;
      lo_r       <= lo_s;
      timer_r    <= timer_s;
      wr_en_r    <= wr_en_s;
      wr_addr_r  <= wr_addr_s;
      wr_data_r  <= wr_data_s;
      done_r     <= done_s;
      err_r      <= err_s;
    end
  end

  assign in_ready   = in_ready_r;
  assign wr_en      = wr_en_r;
  assign wr_sel_isr = sel_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;
  assign core_hold  = hold_r;
  assign load_done  = done_r;
  assign load_err   = err_r;

endmodule

// File: tb/tb_instmem_loader.sv
// Directed self-checking bench for instmem_loader; uses a short timeout so the
// stall scenarios stay fast.
module tb_instmem_loader;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, wr_en, wr_sel_isr, core_hold, load_done, load_err;
  logic [10:0] wr_addr;
  logic [15:0] wr_data;

  int errors = 0;
  int checks = 0;

  logic [10:0] q_addr[$];
  logic [15:0] q_data[$];
  logic        q_sel[$];
  int          n_done = 0;
  int          n_err  = 0;

  instmem_loader #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_sel_isr(wr_sel_isr),
    .wr_addr(wr_addr), .wr_data(wr_data), .core_hold(core_hold),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // Output monitor: logs writes and pulses, checks pulse exclusivity every cycle.
  always @(negedge clk) begin
    if (nrst) begin
      if (wr_en) begin
        q_addr.push_back(wr_addr);
        q_data.push_back(wr_data);
        q_sel.push_back(wr_sel_isr);
      end
      if (load_done) n_done = n_done + 1;
      if (load_err)  n_err  = n_err + 1;
      checks = checks + 1;
      if ((load_done && load_err) || (wr_en && load_err)) begin
        errors = errors + 1;
        $display("FAIL exclusive: done=%0b err=%0b wr_en=%0b required no overlap", load_done, load_err, wr_en);
      end
    end
  end

  task automatic clear_log();
    q_addr.delete(); q_data.delete(); q_sel.delete();
    n_done = 0; n_err = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    idle(3);
    checks = checks + 1;
    if ({in_ready, wr_en, wr_sel_isr, wr_addr, wr_data, core_hold, load_done, load_err} !==
        {1'b1, 1'b0, 1'b0, 11'h000, 16'h0000, 1'b0, 1'b0, 1'b0}) begin
      errors = errors + 1;
      $display("FAIL reset: rdy=%0b we=%0b sel=%0b a=%h d=%h hold=%0b done=%0b err=%0b required 1 0 0 000 0000 0 0 0",
               in_ready, wr_en, wr_sel_isr, wr_addr, wr_data, core_hold, load_done, load_err);
    end
    nrst = 1'b1;
    idle(2);
  endtask

  task automatic test_prog_frame();
    clear_log();
    send_byte(8'hA5);
    checks = checks + 1;
    if (core_hold !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL prog_hold_set: got %0b required 1", core_hold);
    end
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'hB7); send_byte(8'h02);
    send_byte(8'hA6);
    idle(2);
    checks = checks + 1;
    if (q_addr.size() !== 2) begin
      errors = errors + 1;
      $display("FAIL prog_wr_count: got %0d required 2", q_addr.size());
    end else begin
      checks = checks + 1;
      if ({q_addr[0], q_data[0], q_sel[0], q_addr[1], q_data[1], q_sel[1]} !==
          {11'h000, 16'h0013, 1'b0, 11'h001, 16'h02B7, 1'b0}) begin
        errors = errors + 1;
        $display("FAIL prog_writes: got %h:%h/%0b %h:%h/%0b required 000:0013/0 001:02b7/0",
                 q_addr[0], q_data[0], q_sel[0], q_addr[1], q_data[1], q_sel[1]);
      end
    end
    checks = checks + 1;
    if ({n_done, n_err, core_hold} !== {32'd1, 32'd0, 1'b0}) begin
      errors = errors + 1;
      $display("FAIL prog_done: done=%0d err=%0d hold=%0b required 1 0 0", n_done, n_err, core_hold);
    end
  endtask

  task automatic test_isr_bad_csum();
    clear_log();
    send_byte(8'h5A); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h34); send_byte(8'h12); send_byte(8'h00);
    idle(2);
    checks = checks + 1;
    if (q_addr.size() !== 1) begin
      errors = errors + 1;
      $display("FAIL isr_wr_count: got %0d required 1", q_addr.size());
    end else begin
      checks = checks + 1;
      if ({q_addr[0], q_data[0], q_sel[0]} !== {11'h000, 16'h1234, 1'b1}) begin
        errors = errors + 1;
        $display("FAIL isr_write: got %h:%h/%0b required 000:1234/1", q_addr[0], q_data[0], q_sel[0]);
      end
    end
    checks = checks + 1;
    if ({n_done, n_err, core_hold} !== {32'd0, 32'd1, 1'b1}) begin
      errors = errors + 1;
      $display("FAIL isr_err: done=%0d err=%0d hold=%0b required 0 1 1", n_done, n_err, core_hold);
    end
  endtask

  task automatic test_len_bounds();
    clear_log();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    idle(2);
    checks = checks + 1;
    if ({n_err, n_done, q_addr.size(), core_hold} !== {32'd1, 32'd0, 32'd0, 1'b1}) begin
      errors = errors + 1;
      $display("FAIL len_zero: err=%0d done=%0d wr=%0d hold=%0b required 1 0 0 1", n_err, n_done, q_addr.size(), core_hold);
    end
    clear_log();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h08);
    idle(2);
    checks = checks + 1;
    if ({n_err, n_done, q_addr.size()} !== {32'd1, 32'd0, 32'd0}) begin
      errors = errors + 1;
      $display("FAIL len_over: err=%0d done=%0d wr=%0d required 1 0 0", n_err, n_done, q_addr.size());
    end
  endtask

  task automatic test_resync();
    clear_log();
    send_byte(8'hFF); send_byte(8'h00); send_byte(8'h3C);
    idle(2);
    checks = checks + 1;
    if ({n_err, core_hold} !== {32'd0, 1'b1}) begin
      errors = errors + 1;
      $display("FAIL resync_garbage: err=%0d hold=%0b required 0 1", n_err, core_hold);
    end
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hCD); send_byte(8'hAB); send_byte(8'h66);
    idle(2);
    checks = checks + 1;
    if ({n_done, n_err, core_hold, q_addr.size()} !== {32'd1, 32'd0, 1'b0, 32'd1}) begin
      errors = errors + 1;
      $display("FAIL resync_frame: done=%0d err=%0d hold=%0b wr=%0d required 1 0 0 1", n_done, n_err, core_hold, q_addr.size());
    end else begin
      checks = checks + 1;
      if ({q_addr[0], q_data[0]} !== {11'h000, 16'hABCD}) begin
        errors = errors + 1;
        $display("FAIL resync_write: got %h:%h required 000:abcd", q_addr[0], q_data[0]);
      end
    end
  endtask

  task automatic test_timeout();
    clear_log();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h11);
    idle(TO - 1);
    send_byte(8'h22);
    idle(TO - 1);
    send_byte(8'h33);
    idle(2);
    checks = checks + 1;
    if ({n_err, n_done, q_addr.size()} !== {32'd0, 32'd1, 32'd1}) begin
      errors = errors + 1;
      $display("FAIL timeout_edge: err=%0d done=%0d wr=%0d required 0 1 1", n_err, n_done, q_addr.size());
    end
    clear_log();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h44);
    idle(TO - 2);
    checks = checks + 1;
    if (n_err !== 0) begin
      errors = errors + 1;
      $display("FAIL timeout_early: err=%0d required 0", n_err);
    end
    idle(4);
    checks = checks + 1;
    if ({n_err, n_done, q_addr.size(), core_hold} !== {32'd1, 32'd0, 32'd0, 1'b1}) begin
      errors = errors + 1;
      $display("FAIL timeout_fire: err=%0d done=%0d wr=%0d hold=%0b required 1 0 0 1", n_err, n_done, q_addr.size(), core_hold);
    end
  endtask

  task automatic test_reset_midframe_and_full_load();
    logic [7:0]  cs;
    logic [15:0] d;
    int          bad;
    clear_log();
    send_byte(8'h5A); send_byte(8'h00); send_byte(8'h08);
    for (int i = 0; i < 10; i++) begin
      send_byte(8'(i)); send_byte(8'hEE);
    end
    send_byte(8'h77);
    nrst = 1'b0;
    #1;
    checks = checks + 1;
    if ({wr_en, wr_sel_isr, wr_addr, wr_data, core_hold, load_done, load_err, in_ready} !==
        {1'b0, 1'b0, 11'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors = errors + 1;
      $display("FAIL midreset_outputs: we=%0b sel=%0b a=%h d=%h hold=%0b done=%0b err=%0b rdy=%0b required 0 0 000 0000 0 0 0 1",
               wr_en, wr_sel_isr, wr_addr, wr_data, core_hold, load_done, load_err, in_ready);
    end
    idle(2);
    nrst = 1'b1;
    idle(5);
    checks = checks + 1;
    if ({q_addr.size(), n_err, n_done} !== {32'd10, 32'd0, 32'd0}) begin
      errors = errors + 1;
      $display("FAIL midreset_no_write: wr=%0d err=%0d done=%0d required 10 0 0", q_addr.size(), n_err, n_done);
    end
    clear_log();
    cs = 8'h00;
    send_byte(8'h5A); send_byte(8'h00); send_byte(8'h08);
    for (int i = 0; i < 2048; i++) begin
      d = {8'(i >> 3) ^ 8'hC3, 8'(i)};
      cs = cs ^ d[7:0] ^ d[15:8];
      send_byte(d[7:0]); send_byte(d[15:8]);
    end
    send_byte(cs);
    idle(2);
    checks = checks + 1;
    if ({q_addr.size(), n_done, n_err, core_hold} !== {32'd2048, 32'd1, 32'd0, 1'b0}) begin
      errors = errors + 1;
      $display("FAIL full_load_status: wr=%0d done=%0d err=%0d hold=%0b required 2048 1 0 0", q_addr.size(), n_done, n_err, core_hold);
    end else begin
      bad = 0;
      for (int i = 0; i < 2048; i++) begin
        d = {8'(i >> 3) ^ 8'hC3, 8'(i)};
        if ({q_addr[i], q_data[i], q_sel[i]} !== {11'(i), d, 1'b1}) bad = bad + 1;
      end
      checks = checks + 1;
      if (bad !== 0) begin
        errors = errors + 1;
        $display("FAIL full_load_data: got %0d bad writes required 0", bad);
      end
      checks = checks + 1;
      if (q_addr[2047] !== 11'h7FF) begin
        errors = errors + 1;
        $display("FAIL full_load_last: got %h required 7ff", q_addr[2047]);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_prog_frame();
    test_isr_bad_csum();
    test_len_bounds();
    test_resync();
    test_timeout();
    test_reset_midframe_and_full_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
